// File: rtl/prime_search_engine_pkg.sv
// Shared definitions for the prime search engine: default widths, the
// first odd trial divisor and the search FSM state encoding.
package prime_search_engine_pkg;

  localparam int PSE_WIDTH  = 20;
  localparam int PSE_DWIDTH = 11;

  // Trial division starts at the first odd divisor; 2 is never tried
  // because even candidates are skipped entirely.
  localparam int FIRST_ODD_DIV = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_CAND      = 3'd2,
    S_TEST      = 3'd3,
    S_DIV_WAIT  = 3'd4,
    S_NEXT_DIV  = 3'd5,
    S_NEXT_CAND = 3'd6,
    S_FIN       = 3'd7
  } state_t;

endpackage

// File: rtl/prime_search_engine_rem_unit.sv
// Restoring sequential remainder unit: one quotient bit per cycle, rdy
// pulses WIDTH cycles after an accepted go. A go while running is ignored.
// The divisor must be held stable for the whole operation.
module prime_search_engine_rem_unit
  import prime_search_engine_pkg::*;
#(
  parameter int WIDTH  = PSE_WIDTH,
  parameter int DWIDTH = PSE_DWIDTH
) (
  input  logic              clk,
  input  logic              RTC_Reset,
  input  logic              clear,
  input  logic              go,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic [DWIDTH-1:0] rem,
  output logic              rdy
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  dvd_r;
  logic [DWIDTH-1:0] rem_r;
  logic [CW-1:0]     cnt_r;
  logic              run_r;
  logic              rdy_r;

  logic [DWIDTH:0]   trial;
  logic [DWIDTH:0]   diff;
  logic [DWIDTH-1:0] next_rem;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem_r, dvd_r[WIDTH-1]};
    diff     = trial - {1'b0, divisor};
    next_rem = trial[DWIDTH-1:0];
    if (trial >= {1'b0, divisor}) begin
      next_rem = diff[DWIDTH-1:0];
    end
  end

  // Iteration control: load on go, step WIDTH times, pulse rdy at the end.
  always_ff @(posedge clk or negedge RTC_Reset) begin
    if (!RTC_Reset) begin
      dvd_r <= '0;
      rem_r <= '0;
      cnt_r <= '0;
      run_r <= 1'b0;
      rdy_r <= 1'b0;
    end else if (clear) begin
      dvd_r <= '0;
      rem_r <= '0;
      cnt_r <= '0;
      run_r <= 1'b0;
      rdy_r <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      if (!run_r && go) begin
        dvd_r <= dividend;
        rem_r <= '0;
        cnt_r <= CW'(WIDTH);
        run_r <= 1'b1;
      end else if (run_r) begin
        rem_r <= next_rem;
        dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
        cnt_r <= cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          run_r <= 1'b0;
          rdy_r <= 1'b1;
        end
      end
    end
  end

  assign rem = rem_r;
  assign rdy = rdy_r;

endmodule

// File: rtl/prime_search_engine.sv
// Searches downward from limit-1 for the largest prime strictly below limit,
// testing odd candidates by trial division with odd divisors d while d*d <=
// candidate. d*d is tracked incrementally: (d+2)^2 = d^2 + 4d + 4.
// Handshake: start is a one-cycle request honoured only in IDLE (abort in the
// same cycle wins); busy is high from the cycle after acceptance until the
// result is presented; done pulses for one cycle with prime/found valid and
// those outputs hold until the next completion. abort returns to IDLE at once
// with no done pulse and leaves prime/found untouched.
module prime_search_engine
  import prime_search_engine_pkg::*;
#(
  parameter int WIDTH  = PSE_WIDTH,
  parameter int DWIDTH = PSE_DWIDTH
) (
  input  logic             clk,
  input  logic             RTC_Reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] prime,
  output logic             found,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  localparam int SQW = 2 * DWIDTH;

  state_t            state_r;
  logic [WIDTH-1:0]  lim_r;
  logic [WIDTH-1:0]  cand_r;
  logic [DWIDTH-1:0] d_r;
  logic [SQW-1:0]    sq_r;
  logic              div_go_r;
  logic [WIDTH-1:0]  prime_r;
  logic              found_r;
  logic              busy_r;
  logic              done_r;

  logic [DWIDTH-1:0] rem_w;
  logic              rdy_w;
  logic [SQW-1:0]    cand_ext;
  logic [SQW-1:0]    sq_step;

  prime_search_engine_rem_unit #(
    .WIDTH (WIDTH),
    .DWIDTH(DWIDTH)
  ) u_rem (
    .clk      (clk),
    .RTC_Reset(RTC_Reset),
    .clear    (abort),
    .go       (div_go_r),
    .dividend (cand_r),
    .divisor  (d_r),
    .rem      (rem_w),
    .rdy      (rdy_w)
  );

  // Zero-extended candidate for the d*d comparison and the 4d+4 increment.
  always_comb begin
    cand_ext = {{(SQW-WIDTH){1'b0}}, cand_r};
    sq_step  = {{(SQW-DWIDTH-2){1'b0}}, d_r, 2'b00} + SQW'(4);
  end

  // Search FSM with registered outputs; prime/found change only on entry to FIN.
  always_ff @(posedge clk or negedge RTC_Reset) begin
    if (!RTC_Reset) begin
      state_r  <= S_IDLE;
      lim_r    <= '0;
      cand_r   <= '0;
      d_r      <= '0;
      sq_r     <= '0;
      div_go_r <= 1'b0;
      prime_r  <= '0;
      found_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (abort) begin
      state_r  <= S_IDLE;
      div_go_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      div_go_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            lim_r   <= limit;
            busy_r  <= 1'b1;
            state_r <= S_INIT;
          end
        end
        S_INIT: begin
          if (lim_r < WIDTH'(3)) begin
            prime_r <= '0;
            found_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_FIN;
          end else if (lim_r == WIDTH'(3)) begin
            cand_r  <= WIDTH'(2);
            prime_r <= WIDTH'(2);
            found_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_FIN;
          end else begin
            // Odd limit means limit-1 is even, so start one lower.
            cand_r  <= lim_r[0] ? (lim_r - WIDTH'(2)) : (lim_r - WIDTH'(1));
            state_r <= S_CAND;
          end
        end
        S_CAND: begin
          if (cand_r < WIDTH'(3)) begin
            prime_r <= WIDTH'(2);
            found_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_FIN;
          end else begin
            d_r     <= DWIDTH'(FIRST_ODD_DIV);
            sq_r    <= SQW'(FIRST_ODD_DIV * FIRST_ODD_DIV);
            state_r <= S_TEST;
          end
        end
        S_TEST: begin
          if (sq_r > cand_ext) begin
            prime_r <= cand_r;
            found_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_FIN;
          end else begin
            div_go_r <= 1'b1;
            state_r  <= S_DIV_WAIT;
          end
        end
        S_DIV_WAIT: begin
          if (rdy_w) begin
            state_r <= (rem_w == '0) ? S_NEXT_CAND : S_NEXT_DIV;
          end
        end
        S_NEXT_DIV: begin
          sq_r    <= sq_r + sq_step;
          d_r     <= d_r + DWIDTH'(2);
          state_r <= S_TEST;
        end
        S_NEXT_CAND: begin
          cand_r  <= cand_r - WIDTH'(2);
          state_r <= S_CAND;
        end
        S_FIN: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign prime     = prime_r;
  assign found     = found_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign dbg_state = state_r;

endmodule

// File: tb/tb_prime_search_engine.sv
// Bench for prime_search_engine: directed and random limits compared against
// a plain trial-division reference model through an expected-result queue.
module tb_prime_search_engine;
  import prime_search_engine_pkg::*;

  localparam int W = 20;

  logic         clk;
  logic         RTC_Reset;
  logic         start;
  logic         abort;
  logic [W-1:0] limit;
  logic [W-1:0] prime;
  logic         found;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  logic [W:0] exp_q[$];

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_prime = '0;
  logic         last_found = 1'b0;
  logic         done_prev  = 1'b0;

  prime_search_engine dut (
    .clk      (clk),
    .RTC_Reset(RTC_Reset),
    .start    (start),
    .abort    (abort),
    .limit    (limit),
    .prime    (prime),
    .found    (found),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: largest prime strictly below lim, found when lim >= 3.
  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [W:0] model(input int lim);
    for (int c = lim - 1; c >= 2; c--) begin
      if (is_prime(c)) return {1'b1, W'(c)};
    end
    return '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse pops and compares one expectation.
  always @(negedge clk) begin
    if (RTC_Reset === 1'b1) begin
      if (done) begin
        total++;
        if (done_prev) begin
          bad++;
          $display("FAIL done_width: done high two cycles in a row");
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: prime=%0d found=%0d with nothing expected", prime, found);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          if ({found, prime} !== e) begin
            bad++;
            $display("FAIL result: got prime=%0d found=%0d expected prime=%0d found=%0d",
                     prime, found, e[W-1:0], e[W]);
          end
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  // Driver tasks
  task automatic issue_start(input logic [W-1:0] lim);
    @(negedge clk);
    limit = lim;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int lim, input int budget, input int max_lat);
    logic [W:0] e;
    int cyc;
    bit gap;
    e = model(lim);
    exp_q.push_back(e);
    issue_start(W'(lim));
    cyc = 1;
    gap = 1'b0;
    while (!done && cyc < budget) begin
      if (!busy) gap = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: limit=%0d no done after %0d cycles", lim, cyc);
      void'(exp_q.pop_back());
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end else begin
      check($sformatf("busy_continuous lim=%0d", lim), {31'b0, gap}, 32'd0);
      check($sformatf("busy_low_at_done lim=%0d", lim), {31'b0, busy}, 32'd0);
      if (max_lat > 0) check($sformatf("latency_ok lim=%0d", lim), {31'b0, cyc <= max_lat}, 32'd1);
      last_prime = e[W-1:0];
      last_found = e[W];
      @(negedge clk);
    end
  endtask

  initial begin
    int budget;
    budget = 40000;
    RTC_Reset = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    limit     = '0;
    repeat (3) @(negedge clk);
    check("reset_prime", 32'(prime), 32'd0);
    check("reset_found", {31'b0, found}, 32'd0);
    check("reset_busy",  {31'b0, busy},  32'd0);
    check("reset_done",  {31'b0, done},  32'd0);
    RTC_Reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed limits, including square-candidate boundaries and tiny limits.
    run(10, budget, 0);
    run(11, budget, 0);
    run(26, budget, 0);
    run(50, budget, 0);
    run(3, budget, 3);
    run(2, budget, 3);
    run(1, budget, 3);
    run(0, budget, 3);
    run(1000000, budget, 0);
    run(1048575, budget, 0);

    // Random limits
    for (int i = 0; i < 12; i++) begin
      run(int'($urandom_range(0, 3000)), budget, 0);
    end

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    limit = W'(50);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", {31'b0, busy}, 32'd0);
    check("start_abort_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (5) @(negedge clk);

    // start while busy is ignored; result belongs to the original limit
    begin
      logic [W:0] e;
      int cyc;
      e = model(100);
      exp_q.push_back(e);
      issue_start(W'(100));
      repeat (20) @(negedge clk);
      limit = W'(1000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < budget) begin
        @(negedge clk);
        cyc++;
      end
      check("ignored_start_done_seen", {31'b0, done}, 32'd1);
      if (!done) void'(exp_q.pop_back());
      else begin
        last_prime = e[W-1:0];
        last_found = e[W];
      end
      @(negedge clk);
    end

    // abort mid-search: back to IDLE, no done, outputs unchanged
    issue_start(W'(1000000));
    repeat (300) @(negedge clk);
    check("busy_before_abort", {31'b0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (100) @(negedge clk);
    check("abort_prime_kept", 32'(prime), 32'(last_prime));
    check("abort_found_kept", {31'b0, found}, {31'b0, last_found});

    // asynchronous reset mid-search
    issue_start(W'(1000000));
    repeat (200) @(negedge clk);
    #3;
    RTC_Reset = 1'b0;
    #1;
    check("async_reset_prime", 32'(prime), 32'd0);
    check("async_reset_found", {31'b0, found}, 32'd0);
    check("async_reset_busy",  {31'b0, busy},  32'd0);
    check("async_reset_done",  {31'b0, done},  32'd0);
    @(negedge clk);
    RTC_Reset = 1'b1;
    @(negedge clk);
    run(20, budget, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
